mux_arb_reg: RTL and testbench

Parametrised N-channel, W-bit registered bus multiplexer with valid/ready handshaking for the MY8CPU datapath. It generalises the fixed 4×8 operand selector. A direct mode selects a channel by an explicit select code. A round-robin mode arbitrates fairly among requesting channels. The chosen word lands in a single output register, with backpressure, and is tagged with its source channel.

---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/mux_arb_reg_rr_pick.sv | 40 ++++
 rtl/mux_arb_reg.sv | 110 +++++++++++
 tb/tb_mux_arb_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the registered N-channel bus multiplexer/arbiter:
// mode encodings and the helper used to size channel codes.
package mux_arb_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Channel-code width, never narrower than one bit so CH=1 still has a code.
   function automatic int sel_width(input int ch);
      return (clog2(ch) < 1) ? 1 : clog2(ch);
   endfunction

endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// Combinational round-robin picker: finds the first requesting channel
// scanning from ptr upward and wrapping modulo CH (not modulo 2^SELW).
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int CH   = 4,
   parameter int SELW = sel_width(CH)
) (
   input  logic [CH-1:0]   req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] index
);

   localparam int              SW1  = SELW + 1;
   localparam logic [SW1-1:0]  CH_W = SW1'(CH);

   logic [2*CH-1:0] dbl;
   logic [2*CH-1:0] rot;
   logic [SW1-1:0]  sum;

   // Doubling the request vector makes the rotate a plain shift, so bit i of
   // rot is channel (ptr + i) mod CH for every i < CH.
   assign dbl = {req, req};
   assign rot = dbl >> ptr;

   // Take the lowest set bit of the rotated vector and undo the rotation.
   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < CH; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + SW1'(i);
         end
      end
      index = (sum >= CH_W) ? SELW'(sum - CH_W) : sum[SELW-1:0];
   end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N-channel, W-bit bus multiplexer with valid/ready handshaking.
// Direct mode picks the channel named by SEL; round-robin mode arbitrates
// fairly from PTR. The winner lands in one output register tagged with its
// channel code; the register only reloads when empty or being drained.
module mux_arb_reg
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int CH    = 4,
   localparam int SELW  = sel_width(CH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MODE,
   input  logic [SELW-1:0]       SEL,
   input  logic [CH*WIDTH-1:0]   IN_DATA,
   input  logic [CH-1:0]         IN_VALID,
   output logic [CH-1:0]         IN_READY,
   output logic [WIDTH-1:0]      OUT_DATA,
   output logic [SELW-1:0]       OUT_CH,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY
);

   localparam int              NPAD = 1 << SELW;
   localparam int              SW1  = SELW + 1;
   localparam logic [SW1-1:0]  CH_W = SW1'(CH);

   logic [SELW-1:0]  ptr;
   logic             rr_found;
   logic [SELW-1:0]  rr_index;
   logic [NPAD-1:0]  valid_pad;
   logic [SELW-1:0]  dir_sel;
   logic             dir_found;
   logic             load;
   logic             cand;
   logic             grant;
   logic [SELW-1:0]  g;
   logic [WIDTH-1:0] g_data;
   logic [SW1-1:0]   g_inc;
   logic [SELW-1:0]  ptr_next;

   rr_pick #(
      .CH   (CH),
      .SELW (SELW)
   ) u_rr_pick (
      .req   (IN_VALID),
      .ptr   (ptr),
      .found (rr_found),
      .index (rr_index)
   );

   // Codes at or above CH index zero padding, so an out-of-range SEL simply
   // finds no request. With a single channel SEL is ignored entirely.
   assign valid_pad = NPAD'(IN_VALID);
   assign dir_sel   = (CH == 1) ? '0 : SEL;
   assign dir_found = valid_pad[dir_sel];

   assign load  = !OUT_VALID || OUT_READY;
   assign grant = load && cand;

   // Choose the candidate channel according to the current mode.
   always_comb begin
      cand = 1'b0;
      g    = '0;
      if (MODE == MODE_RR) begin
         cand = rr_found;
         g    = rr_index;
      end else begin
         cand = dir_found;
         g    = dir_sel;
      end
   end

   // One-hot accept toward the granted channel plus the matching data word.
   always_comb begin
      IN_READY = '0;
      g_data   = '0;
      for (int k = 0; k < CH; k++) begin
         if (SELW'(k) == g) begin
            IN_READY[k] = grant;
            g_data      = IN_DATA[k*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer advances past the winner, wrapping at CH.
   assign g_inc    = {1'b0, g} + SW1'(1);
   assign ptr_next = (g_inc == CH_W) ? '0 : g_inc[SELW-1:0];

   // Output register and round-robin pointer; everything holds while stalled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_DATA  <= '0;
         OUT_CH    <= '0;
         OUT_VALID <= 1'b0;
         ptr       <= '0;
      end else if (load) begin
         if (cand) begin
            OUT_DATA  <= g_data;
            OUT_CH    <= g;
            OUT_VALID <= 1'b1;
            ptr       <= ptr_next;
         end else begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: a 4-channel and a 3-channel instance driven with
// directed vectors; accepted grants push the expected word into a queue and a
// negedge monitor pops and compares every word the DUT hands downstream.
module tb_mux_arb_reg;
   import mux_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        mode4, ordy4, ov4;
   logic [1:0]  sel4, och4;
   logic [31:0] data4;
   logic [3:0]  valid4, ready4;
   logic [7:0]  odata4;

   logic        mode3, ordy3, ov3;
   logic [1:0]  sel3, och3;
   logic [23:0] data3;
   logic [2:0]  valid3, ready3;
   logic [7:0]  odata3;

   logic [7:0]  tab4 [4];
   logic [7:0]  tab3 [3];
   logic [9:0]  q4 [$];
   logic [9:0]  q3 [$];
   logic [9:0]  e4, e3;

   int errors = 0;
   int checks = 0;

   mux_arb_reg #(.WIDTH(8), .CH(4)) dut4 (
      .CLK(clk), .RST(rst), .MODE(mode4), .SEL(sel4),
      .IN_DATA(data4), .IN_VALID(valid4), .IN_READY(ready4),
      .OUT_DATA(odata4), .OUT_CH(och4), .OUT_VALID(ov4), .OUT_READY(ordy4)
   );

   mux_arb_reg #(.WIDTH(8), .CH(3)) dut3 (
      .CLK(clk), .RST(rst), .MODE(mode3), .SEL(sel3),
      .IN_DATA(data3), .IN_VALID(valid3), .IN_READY(ready3),
      .OUT_DATA(odata3), .OUT_CH(och3), .OUT_VALID(ov3), .OUT_READY(ordy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle on the 4-channel DUT, check IN_READY, queue the winner.
   task automatic step4(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] exp, input bit push);
      @(posedge clk);
      #1;
      mode4 = m; sel4 = s; valid4 = v; ordy4 = r;
      #1;
      chk("in_ready4", 32'(ready4), 32'(exp));
      if (push) begin
         for (int k = 0; k < 4; k++)
            if (exp[k]) q4.push_back({2'(k), tab4[k]});
      end
   endtask

   task automatic step3(input logic m, input logic [1:0] s, input logic [2:0] v,
                        input logic r, input logic [2:0] exp, input bit push);
      @(posedge clk);
      #1;
      mode3 = m; sel3 = s; valid3 = v; ordy3 = r;
      #1;
      chk("in_ready3", 32'(ready3), 32'(exp));
      if (push) begin
         for (int k = 0; k < 3; k++)
            if (exp[k]) q3.push_back({2'(k), tab3[k]});
      end
   endtask

   // Monitor: every word accepted downstream must match the queue head.
   always @(negedge clk) begin
      if (!rst && ov4 && ordy4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out4_unexpected: got ch=%0d data=0x%0h, want nothing", och4, odata4);
         end else begin
            e4 = q4.pop_front();
            chk("out4_word", 32'({och4, odata4}), 32'(e4));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov3 && ordy3) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out3_unexpected: got ch=%0d data=0x%0h, want nothing", och3, odata3);
         end else begin
            e3 = q3.pop_front();
            chk("out3_word", 32'({och3, odata3}), 32'(e3));
         end
      end
   end

   initial begin
      tab4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      tab3 = '{8'hA1, 8'hB2, 8'hC3};
      data4 = {8'h44, 8'h33, 8'h22, 8'h11};
      data3 = {8'hC3, 8'hB2, 8'hA1};
      rst = 1'b1;
      mode4 = MODE_DIRECT; sel4 = 2'd0; valid4 = 4'b0000; ordy4 = 1'b1;
      mode3 = MODE_DIRECT; sel3 = 2'd0; valid3 = 3'b000;  ordy3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid4", 32'(ov4), 32'd0);
      chk("rst_data4", 32'(odata4), 32'h00);
      chk("rst_valid3", 32'(ov3), 32'd0);
      rst = 1'b0;

      // Direct select of ch2, then ch2 drops its request.
      step4(MODE_DIRECT, 2'd2, 4'b1111, 1'b1, 4'b0100, 1);
      step4(MODE_DIRECT, 2'd2, 4'b1011, 1'b1, 4'b0000, 0);
      // Switch to round-robin: continues from ch3, then full rotation.
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1);
      chk("direct_drop_valid", 32'(ov4), 32'd0);
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1);
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1);
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1);
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1);
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1);
      // Only ch1 and ch3 requesting.
      step4(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1);
      step4(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1);
      step4(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1);
      step4(MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1);
      // Backpressure with 0x22 held for three cycles, then release.
      step4(MODE_RR, 2'd0, 4'b0010, 1'b1, 4'b0010, 1);
      for (int i = 0; i < 3; i++) begin
         step4(MODE_DIRECT, 2'd3, 4'b1111, 1'b0, 4'b0000, 0);
         chk("stall_data4", 32'(odata4), 32'h22);
         chk("stall_ch4", 32'(och4), 32'd1);
      end
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1);
      step4(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 0);
      step4(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 0);
      chk("idle_valid4", 32'(ov4), 32'd0);

      // Reset while holding a stalled word clears outputs without a clock edge.
      step4(MODE_RR, 2'd0, 4'b1111, 1'b0, 4'b1000, 0);
      @(posedge clk);
      #1;
      valid4 = 4'b0000;
      #1;
      chk("held_valid4", 32'(ov4), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid4", 32'(ov4), 32'd0);
      chk("async_rst_data4", 32'(odata4), 32'h00);
      chk("async_rst_ch4", 32'(och4), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step4(MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1);
      step4(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 0);
      step4(MODE_RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 0);

      // Three channels: round-robin wraps at 3, SEL=3 selects nothing.
      step3(MODE_RR, 2'd0, 3'b111, 1'b1, 3'b001, 1);
      step3(MODE_RR, 2'd0, 3'b111, 1'b1, 3'b010, 1);
      step3(MODE_RR, 2'd0, 3'b111, 1'b1, 3'b100, 1);
      step3(MODE_RR, 2'd0, 3'b111, 1'b1, 3'b001, 1);
      step3(MODE_DIRECT, 2'd3, 3'b111, 1'b1, 3'b000, 0);
      step3(MODE_DIRECT, 2'd3, 3'b111, 1'b1, 3'b000, 0);
      chk("sel3_valid3", 32'(ov3), 32'd0);
      step3(MODE_DIRECT, 2'd0, 3'b000, 1'b1, 3'b000, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("q4_drained", 32'(q4.size()), 32'd0);
      chk("q3_drained", 32'(q3.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
